// File: rtl/rca_bist_pkg.sv
// Shared constants, state encoding and MISR next-state function for the
// ripple-carry adder BIST output response analyser.
package rca_bist_pkg;

   localparam int N  = 4;
   localparam int CW = 3;
   localparam int SW = N + 1;

   localparam logic [SW-1:0] SEED       = 5'h00;
   localparam logic [SW-1:0] GOLDEN_SIG = 5'h17;
   localparam logic [SW-1:0] MISR_TAPS  = 5'b00101;
   localparam logic [CW-1:0] LAST_COUNT = {CW{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Shift left one place, feed the MSB back through the tap mask, then fold in
   // the response word.
   function automatic logic [SW-1:0] misr_next(input logic [SW-1:0] s,
                                               input logic [SW-1:0] d);
      return {s[SW-2:0], 1'b0} ^ (s[SW-1] ? MISR_TAPS : '0) ^ d;
   endfunction

endpackage

// File: rtl/bist_misr.sv
// Parallel-input LFSR (MISR) that compacts the CUT responses into a signature.
module bist_misr
   import rca_bist_pkg::*;
(
   input  logic          clk,
   input  logic          init,
   input  logic          load,
   input  logic          en,
   input  logic [SW-1:0] d,
   output logic [SW-1:0] sig
);

   // load seeds and folds the first word in one edge; en folds later words
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         sig <= SEED;
      end else if (load) begin
         sig <= misr_next(SEED, d);
      end else if (en) begin
         sig <= misr_next(sig, d);
      end
   end

endmodule

// File: rtl/rca_ora.sv
// Output response analyser for the 4-bit ripple-carry adder BIST.
//
//  state | meaning
//  IDLE  | waiting for test=1 with count==0; last results stay visible
//  RUN   | one vector sampled per edge until the last count is taken
//  DONE  | results frozen and valid until test drops
module rca_ora
   import rca_bist_pkg::*;
(
   input  logic          clk,
   input  logic          init,
   input  logic          test,
   input  logic [CW-1:0] count,
   input  logic [N-1:0]  at,
   input  logic [N-1:0]  bt,
   input  logic          cint,
   input  logic [N-1:0]  sum,
   input  logic          cout,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [CW:0]   fail_cnt,
   output logic [CW-1:0] first_fail,
   output logic [SW-1:0] signature
);

   state_t        state, state_nx;
   logic          start, sample, mismatch;
   logic [SW-1:0] resp, golden, sig_nx;
   logic [CW:0]   fail_cnt_nx;

   assign resp     = {cout, sum};
   assign golden   = {1'b0, at} + {1'b0, bt} + {{N{1'b0}}, cint};
   assign mismatch = (resp != golden);

   // Start folds vector 0 into a fresh count; later samples accumulate.
   assign fail_cnt_nx = (start ? '0 : fail_cnt) + {{CW{1'b0}}, mismatch};
   assign sig_nx      = misr_next(start ? SEED : signature, resp);

   // state register
   always_ff @(posedge clk or posedge init) begin
      if (init) state <= IDLE;
      else      state <= state_nx;
   end

   // next-state decode and per-edge sampling strobes
   always_comb begin
      state_nx = state;
      start    = 1'b0;
      sample   = 1'b0;
      case (state)
         IDLE: begin
            if (test && count == '0) begin
               start    = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (!test) begin
               state_nx = IDLE;
            end else begin
               sample = 1'b1;
               if (count == LAST_COUNT) state_nx = DONE;
            end
         end
         DONE: begin
            if (!test) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // status flags, failure counter and first-failure index
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail_cnt   <= '0;
         first_fail <= '0;
      end else begin
         busy <= (state_nx == RUN);
         done <= (state_nx == DONE);
         if (state == RUN && state_nx == DONE) begin
            pass <= (fail_cnt_nx == '0) && (sig_nx == GOLDEN_SIG);
         end else if (state_nx != DONE) begin
            pass <= 1'b0;
         end
         if (start || sample) begin
            fail_cnt <= fail_cnt_nx;
            if (start) first_fail <= '0;
            if (mismatch && (start || fail_cnt == '0)) first_fail <= count;
         end
      end
   end

   bist_misr u_misr (
      .clk  (clk),
      .init (init),
      .load (start),
      .en   (sample),
      .d    (resp),
      .sig  (signature)
   );

endmodule
